// File: rtl/fwd_packet_tx.sv
// Forwarding-path transmitter: serialises header, payload bytes from packet memory and an XOR checksum.
// A frame addressed to this node is never sent; it is reported through loopback instead.
module fwd_packet_tx #(
   parameter int MEM_DEPTH  = 1024,
   parameter int MEM_WIDTH  = 8,
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_W     = 10
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
   input  logic [WORD_WIDTH-1:0] destinationID,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [7:0]            payload_len,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [MEM_WIDTH-1:0]  mem_rdata,
   output logic [MEM_WIDTH-1:0]  tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  busy,
   output logic                  done,
   output logic                  loopback
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_PAY, S_CSUM, S_DONE} state_t;

   state_t                state, state_next;
   logic [WORD_WIDTH-1:0] dst, src;
   logic [ADDR_W-1:0]     base;
   logic [7:0]            len, pay_idx;
   logic [2:0]            hdr_idx;
   logic [MEM_WIDTH-1:0]  csum, pay_hold, hdr_byte;
   logic                  pay_first, is_lb;
   logic [ADDR_W:0]       addr_sum;
   logic [ADDR_W-1:0]     fetch_addr;
   logic                  fire;

   // One spare bit so the wrap works for any depth, not only powers of two.
   assign addr_sum = {1'b0, base} + (ADDR_W+1)'(pay_idx);
   assign fetch_addr = ADDR_W'((addr_sum >= (ADDR_W+1)'(MEM_DEPTH)) ?
                               addr_sum - (ADDR_W+1)'(MEM_DEPTH) : addr_sum);
   assign fire = tx_valid && tx_ready;

   always_comb begin
      hdr_byte = '0;
      case (hdr_idx)
         3'd0:    hdr_byte = dst[WORD_WIDTH-1 -: MEM_WIDTH];
         3'd1:    hdr_byte = dst[MEM_WIDTH-1:0];
         3'd2:    hdr_byte = src[WORD_WIDTH-1 -: MEM_WIDTH];
         3'd3:    hdr_byte = src[MEM_WIDTH-1:0];
         default: hdr_byte = MEM_WIDTH'(len);
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      mem_addr   = '0;
      tx_data    = '0;
      tx_valid   = 1'b0;
      tx_last    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      loopback   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = (destinationID == MY_NODE_ID) ? S_DONE : S_HDR;
         end
         S_HDR: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = hdr_byte;
            if (tx_ready && hdr_idx == 3'd4) state_next = (len == 8'd0) ? S_CSUM : S_FETCH;
         end
         S_FETCH: begin
            busy       = 1'b1;
            mem_addr   = fetch_addr;
            state_next = S_PAY;
         end
         S_PAY: begin
            // Address is held so read data stays valid; the held copy covers long stalls.
            busy     = 1'b1;
            tx_valid = 1'b1;
            mem_addr = fetch_addr;
            tx_data  = pay_first ? mem_rdata : pay_hold;
            if (tx_ready) state_next = (pay_idx == len - 8'd1) ? S_CSUM : S_FETCH;
         end
         S_CSUM: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_last  = 1'b1;
            tx_data  = csum;
            if (tx_ready) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            loopback   = is_lb;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         dst       <= '0;
         src       <= '0;
         base      <= '0;
         len       <= '0;
         hdr_idx   <= '0;
         pay_idx   <= '0;
         csum      <= '0;
         pay_hold  <= '0;
         pay_first <= 1'b0;
         is_lb     <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            dst     <= destinationID;
            src     <= MY_NODE_ID;
            base    <= base_addr;
            len     <= payload_len;
            hdr_idx <= '0;
            pay_idx <= '0;
            csum    <= '0;
            is_lb   <= (destinationID == MY_NODE_ID);
         end
         if (fire) csum <= csum ^ tx_data;
         if (fire && state == S_HDR) hdr_idx <= hdr_idx + 3'd1;
         if (fire && state == S_PAY) pay_idx <= pay_idx + 8'd1;
         pay_first <= (state == S_FETCH);
         if (state == S_PAY && pay_first) pay_hold <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_fwd_packet_tx.sv
// Scoreboard bench for fwd_packet_tx: expected frame bytes are queued at start and popped on handshake.
module tb_fwd_packet_tx;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] MY_NODE_ID = '0;
   logic [15:0] destinationID = '0;
   logic [9:0]  base_addr = '0;
   logic [7:0]  payload_len = '0;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        tx_last;
   logic        busy;
   logic        done;
   logic        loopback;

   fwd_packet_tx dut (
      .clock(clock), .rst(rst), .start(start), .MY_NODE_ID(MY_NODE_ID),
      .destinationID(destinationID), .base_addr(base_addr), .payload_len(payload_len),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .done(done), .loopback(loopback)
   );

   always #5 clock = ~clock;

   // Synchronous-read packet memory: data for an address appears the cycle after.
   logic [7:0] mem [1024];
   always @(posedge clock) mem_rdata <= mem[mem_addr];

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       exp_q [$];
   logic [9:0] addr_q [$];
   int         checks = 0;
   int         errors = 0;
   int         rx_count = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;
   exp_t       mon_e;

   int r_done, r_lb, r_valid, r_busy, r_cyc_done;
   logic r_lb_at_done, r_busy_at_done;

   // Output monitor: byte scoreboard, stall stability and fetch-address log.
   always @(negedge clock) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                        tx_valid, tx_data, tx_last, prev_data, prev_last);
            end
         end
         if (busy && !tx_valid) addr_q.push_back(mem_addr);
         if (tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: data=%h last=%b, required no byte", tx_data, tx_last);
            end else begin
               mon_e = exp_q.pop_front();
               if (tx_data !== mon_e.data || tx_last !== mon_e.last) begin
                  errors++;
                  $display("FAIL frame_byte[%0d]: data=%h last=%b, required data=%h last=%b",
                           rx_count, tx_data, tx_last, mon_e.data, mon_e.last);
               end
            end
            rx_count++;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_last  = tx_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic clear_sb();
      exp_q.delete();
      addr_q.delete();
      rx_count = 0;
   endtask

   task automatic push_frame(input logic [15:0] d, input logic [15:0] s,
                             input logic [7:0] len, input logic [9:0] base);
      logic [7:0] b [$];
      logic [7:0] cs;
      cs = 8'h00;
      b.push_back(d[15:8]);
      b.push_back(d[7:0]);
      b.push_back(s[15:8]);
      b.push_back(s[7:0]);
      b.push_back(len);
      for (int i = 0; i < int'(len); i++) b.push_back(mem[10'((int'(base) + i) % 1024)]);
      foreach (b[i]) begin
         exp_q.push_back('{data: b[i], last: 1'b0});
         cs ^= b[i];
      end
      exp_q.push_back('{data: cs, last: 1'b1});
   endtask

   task automatic start_frame(input logic [15:0] d, input logic [15:0] s,
                              input logic [7:0] len, input logic [9:0] base);
      destinationID = d;
      MY_NODE_ID    = s;
      payload_len   = len;
      base_addr     = base;
      start         = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Cycle 0 is the cycle after start was accepted; runs until 3 cycles past the first done.
   task automatic run_frame(input int sa_idx, input int sa_len, input int sb_idx, input int sb_len,
                            input int pulse_a, input int pulse_b);
      int sa = 0;
      int sb = 0;
      r_done = 0; r_lb = 0; r_valid = 0; r_busy = 0; r_cyc_done = -1;
      r_lb_at_done = 1'b0; r_busy_at_done = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         tx_ready = 1'b1;
         if (tx_valid && rx_count == sa_idx && sa < sa_len) begin
            tx_ready = 1'b0; sa++;
         end else if (tx_valid && rx_count == sb_idx && sb < sb_len) begin
            tx_ready = 1'b0; sb++;
         end
         start = (cyc == pulse_a || cyc == pulse_b);
         if (start) begin
            destinationID = 16'h7777; MY_NODE_ID = 16'h7777;
            payload_len = 8'd5; base_addr = 10'h200;
         end
         @(negedge clock);
         if (tx_valid) r_valid++;
         if (busy) r_busy++;
         if (loopback) r_lb++;
         if (done) begin
            r_done++;
            if (r_cyc_done < 0) begin
               r_cyc_done = cyc; r_lb_at_done = loopback; r_busy_at_done = busy;
            end
         end
         @(posedge clock); #1;
         if (r_cyc_done >= 0 && cyc >= r_cyc_done + 3) break;
      end
      start = 1'b0;
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({tx_valid, tx_last, busy, done, loopback} !== 5'b0 || tx_data !== 8'h00 || mem_addr !== 10'h000) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b last=%b busy=%b done=%b lb=%b data=%h addr=%h, required all 0",
                  tx_valid, tx_last, busy, done, loopback, tx_data, mem_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      clear_sb();
      push_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      start_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      run_frame(-1, 0, -1, 0, -1, -1);
      checks++;
      if (r_cyc_done !== 12) begin errors++; $display("FAIL basic_done_cycle: got %0d, want 12", r_cyc_done); end
      checks++;
      if (r_done !== 1 || r_lb !== 0 || r_busy_at_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: done_cycles=%0d lb_cycles=%0d busy_at_done=%b, want 1 0 0",
                  r_done, r_lb, r_busy_at_done);
      end
      checks++;
      if (r_valid !== 9 || r_busy !== 12) begin
         errors++; $display("FAIL basic_valid_busy: valid=%0d busy=%0d, want 9 12", r_valid, r_busy);
      end
      checks++;
      if (rx_count !== 9 || exp_q.size() !== 0) begin
         errors++; $display("FAIL basic_count: rx=%0d left=%0d, want 9 0", rx_count, exp_q.size());
      end
      checks++;
      if (addr_q.size() !== 3 || addr_q[0] !== 10'h010 || addr_q[1] !== 10'h011 || addr_q[2] !== 10'h012) begin
         errors++; $display("FAIL basic_addr: %0d fetches, want 010 011 012", addr_q.size());
      end
   endtask

   task automatic test_zero_len();
      clear_sb();
      push_frame(16'h0001, 16'h0002, 8'd0, 10'h123);
      start_frame(16'h0001, 16'h0002, 8'd0, 10'h123);
      run_frame(-1, 0, -1, 0, -1, -1);
      checks++;
      if (r_cyc_done !== 6 || r_valid !== 6) begin
         errors++; $display("FAIL zero_len_timing: done_cycle=%0d valid=%0d, want 6 6", r_cyc_done, r_valid);
      end
      checks++;
      if (rx_count !== 6 || exp_q.size() !== 0) begin
         errors++; $display("FAIL zero_len_count: rx=%0d left=%0d, want 6 0", rx_count, exp_q.size());
      end
      checks++;
      if (addr_q.size() !== 0) begin
         errors++; $display("FAIL zero_len_mem: %0d fetches, want 0", addr_q.size());
      end
   endtask

   task automatic test_wrap();
      clear_sb();
      push_frame(16'h0BAD, 16'h0C0D, 8'd4, 10'h3FE);
      start_frame(16'h0BAD, 16'h0C0D, 8'd4, 10'h3FE);
      run_frame(-1, 0, -1, 0, -1, -1);
      checks++;
      if (r_cyc_done !== 14 || rx_count !== 10 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL wrap_frame: done_cycle=%0d rx=%0d left=%0d, want 14 10 0", r_cyc_done, rx_count, exp_q.size());
      end
      checks++;
      if (addr_q.size() !== 4 || addr_q[0] !== 10'h3FE || addr_q[1] !== 10'h3FF ||
          addr_q[2] !== 10'h000 || addr_q[3] !== 10'h001) begin
         errors++; $display("FAIL wrap_addr: %0d fetches, want 3FE 3FF 000 001", addr_q.size());
      end
   endtask

   task automatic test_backpressure();
      clear_sb();
      push_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      start_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      run_frame(2, 5, 6, 3, -1, -1);
      checks++;
      if (r_cyc_done !== 20 || r_valid !== 17) begin
         errors++; $display("FAIL bp_timing: done_cycle=%0d valid=%0d, want 20 17", r_cyc_done, r_valid);
      end
      checks++;
      if (rx_count !== 9 || exp_q.size() !== 0) begin
         errors++; $display("FAIL bp_count: rx=%0d left=%0d, want 9 0", rx_count, exp_q.size());
      end
   endtask

   task automatic test_loopback();
      clear_sb();
      start_frame(16'h0042, 16'h0042, 8'd5, 10'h020);
      run_frame(-1, 0, -1, 0, -1, -1);
      checks++;
      if (r_cyc_done !== 0 || r_done !== 1) begin
         errors++; $display("FAIL lb_done: done_cycle=%0d done_cycles=%0d, want 0 1", r_cyc_done, r_done);
      end
      checks++;
      if (r_lb !== 1 || r_lb_at_done !== 1'b1) begin
         errors++; $display("FAIL lb_flag: lb_cycles=%0d lb_at_done=%b, want 1 1", r_lb, r_lb_at_done);
      end
      checks++;
      if (r_valid !== 0 || r_busy !== 0 || rx_count !== 0 || addr_q.size() !== 0) begin
         errors++;
         $display("FAIL lb_quiet: valid=%0d busy=%0d rx=%0d fetches=%0d, want 0 0 0 0",
                  r_valid, r_busy, rx_count, addr_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int idle_bad = 0;
      int waited = 0;
      clear_sb();
      push_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      start_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      while (rx_count < 6 && waited < 100) begin
         @(posedge clock); #1;
         waited++;
      end
      checks++;
      if (rx_count !== 6) begin
         errors++; $display("FAIL mid_reset_reach: rx=%0d, want 6", rx_count);
      end
      rst = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_abort: valid=%b busy=%b, want 0 0", tx_valid, busy);
      end
      rst = 1'b0;
      clear_sb();
      push_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      start_frame(16'h1234, 16'h00AB, 8'd3, 10'h010);
      run_frame(-1, 0, -1, 0, 3, 12);
      checks++;
      if (r_cyc_done !== 12 || r_done !== 1 || r_lb !== 0) begin
         errors++;
         $display("FAIL restart_done: done_cycle=%0d done_cycles=%0d lb=%0d, want 12 1 0", r_cyc_done, r_done, r_lb);
      end
      checks++;
      if (rx_count !== 9 || exp_q.size() !== 0 || r_valid !== 9) begin
         errors++;
         $display("FAIL restart_frame: rx=%0d left=%0d valid=%0d, want 9 0 9", rx_count, exp_q.size(), r_valid);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (tx_valid || busy || done) idle_bad++;
      end
      checks++;
      if (idle_bad !== 0) begin
         errors++; $display("FAIL ignored_start: %0d active cycles after frame, want 0", idle_bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
      mem[10'h010] = 8'h11;
      mem[10'h011] = 8'h22;
      mem[10'h012] = 8'h33;
      mem[10'h3FE] = 8'hA1;
      mem[10'h3FF] = 8'hB2;
      mem[10'h000] = 8'hC3;
      mem[10'h001] = 8'hD4;
      test_reset();
      test_basic();
      test_zero_len();
      test_wrap();
      test_backpressure();
      test_loopback();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
